flash_programmer: RTL and testbench

- Write-side companion to the StrataFlash read controller: programs single 16-bit words and erases blocks in the parallel Intel-command-set StrataFlash.
- Runs the command sequence, polls the status register, decodes errors and returns the device to read-array mode.
- Top level muxes the SF_* pins between this block and the read controller using `busy` (this block owns the pins while busy=1).

---
 rtl/flash_programmer.sv | 238 +++++++++++++++++++++++
 tb/tb_flash_programmer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_programmer.sv
// Word-program / block-erase sequencer for Intel-command-set StrataFlash (x16 mode).
// Define FLASH_VERIFY_EN to add a read-back compare after a clean word program.
module flash_programmer #(
  parameter int          WE_CYCLES     = 4,
  parameter int          RD_CYCLES     = 6,
  parameter logic [15:0] TIMEOUT_POLLS = 16'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [22:0] addr,
  input  logic [15:0] wdata,
  input  logic        start,
  input  logic        erase,
  output logic        busy,
  output logic        done,
  output logic [2:0]  err_code,
  output logic [7:0]  status,
  input  logic [15:0] sf_d_in,
  output logic [15:0] sf_d_out,
  output logic        sf_d_oe,
  output logic [23:0] SF_A,
  output logic        SF_CE0,
  output logic        SF_OE,
  output logic        SF_WE,
  output logic        SF_BYTE
);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD1, S_CMD2, S_POLL, S_CHECK, S_CLEAR, S_RESTORE, S_VERIFY, S_DONE
  } state_t;

  // Write phases by cnt: 0 setup, 1..WE_CYCLES pulse, +1 hold, +2 released gap.
  localparam logic [7:0] W_PULSE  = 8'(WE_CYCLES);
  localparam logic [7:0] W_LAST   = 8'(WE_CYCLES + 2);
  localparam logic [7:0] R_SAMPLE = 8'(RD_CYCLES - 1);
  localparam logic [7:0] R_LAST   = 8'(RD_CYCLES);

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [15:0] poll_reg, poll_next;
  logic [22:0] addr_reg, addr_next;
  logic [15:0] wdata_reg, wdata_next;
  logic        erase_reg, erase_next;
  logic [2:0]  err_reg, err_next;
  logic [7:0]  status_reg, status_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        ce_reg, ce_next;
  logic        oe_reg, oe_next;
  logic        we_reg, we_next;
  logic        doe_reg, doe_next;
  logic [15:0] dout_reg, dout_next;
  logic [2:0]  chk_err;
`ifdef FLASH_VERIFY_EN
  logic        verify_reg, verify_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      poll_reg   <= '0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      erase_reg  <= 1'b0;
      err_reg    <= '0;
      status_reg <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      ce_reg     <= 1'b1;
      oe_reg     <= 1'b1;
      we_reg     <= 1'b1;
      doe_reg    <= 1'b0;
      dout_reg   <= '0;
`ifdef FLASH_VERIFY_EN
      verify_reg <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      poll_reg   <= poll_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      erase_reg  <= erase_next;
      err_reg    <= err_next;
      status_reg <= status_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      ce_reg     <= ce_next;
      oe_reg     <= oe_next;
      we_reg     <= we_next;
      doe_reg    <= doe_next;
      dout_reg   <= dout_next;
`ifdef FLASH_VERIFY_EN
      verify_reg <= verify_next;
`endif
    end
  end

  // Status-register decode, lock beats VPP beats operation failure.
  always_comb begin
    chk_err = 3'd0;
    if (status_reg[1])
      chk_err = 3'd4;
    else if (status_reg[3])
      chk_err = 3'd3;
    else if (erase_reg && status_reg[5])
      chk_err = 3'd2;
    else if (!erase_reg && status_reg[4])
      chk_err = 3'd1;
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    poll_next   = poll_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    erase_next  = erase_reg;
    err_next    = err_reg;
    status_next = status_reg;
`ifdef FLASH_VERIFY_EN
    verify_next = verify_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_CMD1;
          cnt_next   = '0;
          addr_next  = addr;
          wdata_next = wdata;
          erase_next = erase;
          err_next   = '0;
`ifdef FLASH_VERIFY_EN
          verify_next = 1'b0;
`endif
        end
      end
      S_CMD1, S_CMD2, S_CLEAR, S_RESTORE: begin
        if (cnt_reg == W_LAST) begin
          cnt_next = '0;
          if (state_reg == S_CMD1) begin
            state_next = S_CMD2;
          end else if (state_reg == S_CMD2) begin
            state_next = S_POLL;
            poll_next  = '0;
          end else if (state_reg == S_CLEAR) begin
            state_next = S_RESTORE;
          end else begin
`ifdef FLASH_VERIFY_EN
            state_next = verify_reg ? S_VERIFY : S_DONE;
`else
            state_next = S_DONE;
`endif
          end
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      S_POLL: begin
        if (cnt_reg == R_SAMPLE) begin
          status_next = sf_d_in[7:0];
          poll_next   = poll_reg + 16'd1;
        end
        if (cnt_reg == R_LAST) begin
          cnt_next = '0;
          if (status_reg[7]) begin
            state_next = S_CHECK;
          end else if (poll_reg == TIMEOUT_POLLS) begin
            err_next   = 3'd5;
            state_next = S_RESTORE;
          end
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      S_CHECK: begin
        err_next   = chk_err;
        cnt_next   = '0;
        state_next = (chk_err != 3'd0) ? S_CLEAR : S_RESTORE;
`ifdef FLASH_VERIFY_EN
        verify_next = !erase_reg && (chk_err == 3'd0);
`endif
      end
`ifdef FLASH_VERIFY_EN
      S_VERIFY: begin
        if (cnt_reg == R_SAMPLE && sf_d_in != wdata_reg)
          err_next = 3'd6;
        if (cnt_reg == R_LAST) begin
          cnt_next   = '0;
          state_next = S_DONE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // Pins are registered from the next state so strobes never glitch.
  always_comb begin
    busy_next = (state_next != S_IDLE);
    done_next = (state_next == S_DONE);
    ce_next   = 1'b1;
    oe_next   = 1'b1;
    we_next   = 1'b1;
    doe_next  = 1'b0;
    dout_next = dout_reg;
    if (state_next inside {S_CMD1, S_CMD2, S_CLEAR, S_RESTORE}) begin
      ce_next  = (cnt_next == W_LAST);
      doe_next = (cnt_next != W_LAST);
      we_next  = !((cnt_next >= 8'd1) && (cnt_next <= W_PULSE));
      case (state_next)
        S_CMD1:  dout_next = erase_next ? 16'h0020 : 16'h0040;
        S_CMD2:  dout_next = erase_next ? 16'h00D0 : wdata_next;
        S_CLEAR: dout_next = 16'h0050;
        default: dout_next = 16'h00FF;
      endcase
    end else if (state_next == S_POLL || state_next == S_VERIFY) begin
      ce_next = (cnt_next == R_LAST);
      oe_next = (cnt_next == R_LAST);
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign err_code = err_reg;
  assign status   = status_reg;
  assign sf_d_out = dout_reg;
  assign sf_d_oe  = doe_reg;
  assign SF_A     = {addr_reg, 1'b0};
  assign SF_CE0   = ce_reg;
  assign SF_OE    = oe_reg;
  assign SF_WE    = we_reg;
  assign SF_BYTE  = 1'b1;

endmodule

// File: tb/tb_flash_programmer.sv
// Directed bench for flash_programmer with a scripted StrataFlash status model.
`timescale 1ns/1ps
module tb_flash_programmer;
  localparam int          WE_C = 4;
  localparam int          RD_C = 6;
  localparam logic [15:0] TMO  = 16'd8;
`ifdef FLASH_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, erase = 1'b0;
  logic [22:0] addr = '0;
  logic [15:0] wdata = '0, sf_d_in = '0, sf_d_out;
  logic        busy, done, sf_d_oe, SF_CE0, SF_OE, SF_WE, SF_BYTE;
  logic [2:0]  err_code;
  logic [7:0]  status;
  logic [23:0] SF_A;

  flash_programmer #(.WE_CYCLES(WE_C), .RD_CYCLES(RD_C), .TIMEOUT_POLLS(TMO)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .start(start), .erase(erase),
    .busy(busy), .done(done), .err_code(err_code), .status(status),
    .sf_d_in(sf_d_in), .sf_d_out(sf_d_out), .sf_d_oe(sf_d_oe), .SF_A(SF_A),
    .SF_CE0(SF_CE0), .SF_OE(SF_OE), .SF_WE(SF_WE), .SF_BYTE(SF_BYTE));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [15:0] exp_wr[$], got_wr[$], last_wr[$];
  int          exp_rd, got_rd, last_rd;
  logic [2:0]  exp_err;
  logic [7:0]  exp_status;
  logic [23:0] exp_sfa;
  logic [7:0]  script[8];
  int          script_len = 1, rd_idx = 0, done_cnt = 0;
  bit          array_mode = 1'b1;
  logic [15:0] array_val = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  function automatic logic [15:0] lw(input int i);
    return (i < last_wr.size()) ? last_wr[i] : 16'hDEAD;
  endfunction

  // Operation-level model: command list, status reads and error from the SR script.
  task automatic predict(input bit er, input logic [15:0] wd, input logic [15:0] arr);
    logic [7:0] sr;
    bit tmo = 1'b0;
    int n = 0;
    exp_wr.delete();
    exp_wr.push_back(er ? 16'h0020 : 16'h0040);
    exp_wr.push_back(er ? 16'h00D0 : wd);
    while (1) begin
      sr = script[(n < script_len) ? n : script_len - 1];
      n++;
      if (sr[7]) break;
      if (n == int'(TMO)) begin tmo = 1'b1; break; end
    end
    exp_status = sr;
    if (tmo)                exp_err = 3'd5;
    else if (sr[1])         exp_err = 3'd4;
    else if (sr[3])         exp_err = 3'd3;
    else if (er && sr[5])   exp_err = 3'd2;
    else if (!er && sr[4])  exp_err = 3'd1;
    else                    exp_err = 3'd0;
    if (!tmo && exp_err != 3'd0) exp_wr.push_back(16'h0050);
    exp_wr.push_back(16'h00FF);
    if (VERIFY && !er && exp_err == 3'd0) begin
      n++;
      if (arr != wd) exp_err = 3'd6;
    end
    exp_rd = n;
  endtask

  // Flash model plus per-cycle compare against the model.
  int we_low = 0, oe_low = 0;
  bit prev_we = 1'b1, prev_oe = 1'b1, prev_done = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      we_low = 0; oe_low = 0; prev_we = 1'b1; prev_oe = 1'b1; prev_done = 1'b0;
      got_wr.delete(); got_rd = 0;
    end else begin
      if (!SF_WE) begin
        we_low++;
        check("we_qual", {30'd0, SF_CE0, sf_d_oe}, 32'd1);
      end else if (!prev_we) begin
        check("we_width", we_low, WE_C);
        check("hold_qual", {30'd0, SF_CE0, sf_d_oe}, 32'd1);
        check("wr_addr", SF_A, exp_sfa);
        got_wr.push_back(sf_d_out);
        array_mode = (sf_d_out == 16'h00FF);
        we_low = 0;
      end
      if (!SF_OE) begin
        oe_low++;
        check("oe_qual", {30'd0, SF_CE0, sf_d_oe}, 32'd0);
      end else if (!prev_oe) begin
        check("oe_width", oe_low, RD_C);
        check("rd_addr", SF_A, exp_sfa);
        got_rd++;
        if (!array_mode) rd_idx++;
        oe_low = 0;
      end
      if (done) begin
        done_cnt++;
        check("busy_at_done", busy, 1);
        check("done_err", err_code, exp_err);
        check("done_status", status, exp_status);
        check("done_reads", got_rd, exp_rd);
        check("done_nwr", got_wr.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
          check($sformatf("done_wr%0d", i), got_wr[i], exp_wr[i]);
        last_wr = got_wr;
        last_rd = got_rd;
        got_wr.delete();
        got_rd = 0;
      end
      if (prev_done) begin
        check("busy_after_done", busy, 0);
        check("done_one_cycle", done, 0);
      end
      prev_we = SF_WE; prev_oe = SF_OE; prev_done = done;
    end
    sf_d_in = array_mode ? array_val : {8'h00, script[(rd_idx < script_len) ? rd_idx : script_len - 1]};
  end

  task automatic run_op(input string name, input bit er, input logic [22:0] a,
                        input logic [15:0] wd, input logic [15:0] arr, input bit extra);
    int target = done_cnt + 1;
    int cyc = 0;
    array_val = arr;
    predict(er, wd, arr);
    exp_sfa = {a, 1'b0};
    rd_idx = 0;
    @(posedge clk); #1;
    addr = a; wdata = wd; erase = er; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; addr = ~a; wdata = ~wd; erase = ~er;
    if (extra) begin
      repeat (5) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    while (done_cnt < target && cyc < 3000) begin
      @(posedge clk);
      cyc++;
    end
    check({name, "_completed"}, (done_cnt >= target), 1);
    repeat (3) @(posedge clk);
    check({name, "_err_held"}, err_code, exp_err);
    check({name, "_busy_idle"}, busy, 0);
    $display("op %s erase=%0d addr=%h err=%0d status=%h writes=%0d reads=%0d",
             name, er, a, err_code, status, last_wr.size(), last_rd);
  endtask

  initial begin
    bit found;
    int d0;
    script[0] = 8'h80;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);     check("rst_done", done, 0);
    check("rst_err", err_code, 0);  check("rst_status", status, 0);
    check("rst_doe", sf_d_oe, 0);   check("rst_ce", SF_CE0, 1);
    check("rst_oe", SF_OE, 1);      check("rst_we", SF_WE, 1);
    check("rst_addr", SF_A, 0);     check("rst_byte", SF_BYTE, 1);
    @(posedge clk); #1 rst = 1'b0;

    script[0] = 8'h00; script[1] = 8'h00; script[2] = 8'h80; script_len = 3;
    run_op("prog", 1'b0, 23'h000123, 16'hBEEF, 16'hBEEF, 1'b0);
    check("prog_lit_n", last_wr.size(), 3);
    check("prog_lit_w0", lw(0), 16'h0040);
    check("prog_lit_w1", lw(1), 16'hBEEF);
    check("prog_lit_w2", lw(2), 16'h00FF);
    check("prog_lit_rd", last_rd, VERIFY ? 4 : 3);
    check("prog_lit_err", err_code, 0);
    check("prog_lit_sr", status, 8'h80);

    script[0] = 8'hA0; script_len = 1;
    run_op("erase", 1'b1, 23'h020000, 16'h0000, 16'h0000, 1'b0);
    check("erase_lit_n", last_wr.size(), 4);
    check("erase_lit_w0", lw(0), 16'h0020);
    check("erase_lit_w1", lw(1), 16'h00D0);
    check("erase_lit_w2", lw(2), 16'h0050);
    check("erase_lit_w3", lw(3), 16'h00FF);
    check("erase_lit_err", err_code, 2);

    script[0] = 8'h92;
    run_op("lock", 1'b0, 23'h000400, 16'h1357, 16'h1357, 1'b0);
    check("lock_lit_err", err_code, 4);
    check("lock_lit_clr", lw(2), 16'h0050);

    script[0] = 8'h00;
    run_op("timeout", 1'b0, 23'h7FFFFF, 16'hA5A5, 16'hA5A5, 1'b0);
    check("tmo_lit_rd", last_rd, 8);
    check("tmo_lit_err", err_code, 5);
    check("tmo_lit_n", last_wr.size(), 3);
    check("tmo_lit_ff", lw(2), 16'h00FF);

    script[0] = 8'h88;
    run_op("vpp", 1'b0, 23'h000010, 16'h0F0F, 16'h0F0F, 1'b1);
    check("vpp_lit_err", err_code, 3);
    script[0] = 8'h90;
    run_op("progerr", 1'b0, 23'h000011, 16'h00F0, 16'h00F0, 1'b0);
    check("progerr_lit_err", err_code, 1);
    script[0] = 8'hB0;
    run_op("erase_vs_sr4", 1'b1, 23'h040000, 16'h0000, 16'h0000, 1'b0);
    check("erase_sr4_lit_err", err_code, 2);

    // Abort mid write pulse.
    script[0] = 8'h80;
    exp_sfa = {23'h000055, 1'b0};
    @(posedge clk); #1;
    addr = 23'h000055; wdata = 16'h1234; erase = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (!SF_WE) found = 1'b1;
    end
    check("abort_we_seen", found, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_we", SF_WE, 1);   check("abort_busy", busy, 0);
    check("abort_doe", sf_d_oe, 0); check("abort_ce", SF_CE0, 1);
    d0 = done_cnt;
    repeat (40) @(posedge clk);
    check("abort_no_done", done_cnt, d0);
    $display("op abort addr=000055 done_pulses=%0d", done_cnt - d0);

    script[0] = 8'h00; script[1] = 8'h80; script_len = 2;
    run_op("after_abort", 1'b0, 23'h000055, 16'h1234, 16'h1234, 1'b0);
    check("after_abort_lit_err", err_code, 0);

`ifdef FLASH_VERIFY_EN
    script[0] = 8'h80; script_len = 1;
    run_op("verify_bad", 1'b0, 23'h000123, 16'hBEEF, 16'hBEEE, 1'b0);
    check("verify_lit_err", err_code, 6);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
